mor1kx_rf_ctrl: RTL
===================

# mor1kx_rf_ctrl

Register-file front end that sits directly upstream of the synchronous-read register-file RAMs, one RAM per read port (A, B) sharing one write port. Because the RAMs have no reset and no read-during-write guarantee, this block does three things:
- clears every RAM word after reset;
- resolves same-cycle and held-output write/read hazards with bypass registers;
- optionally forces r0 to zero.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32, data width
- OPTION_RF_ADDR_WIDTH, 5, register address width
- OPTION_RF_WORDS, 32, number of registers cleared at init
- OPTION_RF_R0_ZERO, 1, 1 = writes to address 0 suppressed

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- busy_o  out  1  init sequence running; upstream must not read or write
- rfa_adr_i  in  ADDR  port A read address
- rfb_adr_i  in  ADDR  port B read address
- rf_re_i  in  1  read enable, both ports
- rfa_o  out  WIDTH  port A read data
- rfb_o  out  WIDTH  port B read data
- wb_adr_i  in  ADDR  writeback address
- wb_we_i  in  1  writeback enable
- wb_dat_i  in  WIDTH  writeback data
- ram_rdad_a_o  out  ADDR  read address to RAM A
- ram_rdad_b_o  out  ADDR  read address to RAM B
- ram_rden_o  out  1  read enable to both RAMs
- ram_rdda_a_i  in  WIDTH  RAM A read data
- ram_rdda_b_i  in  WIDTH  RAM B read data
- ram_wrad_o  out  ADDR  write address to both RAMs
- ram_wren_o  out  1  write enable to both RAMs
- ram_wrda_o  out  WIDTH  write data to both RAMs

## Operation
- States: INIT, RUN. Reset enters INIT with counter = 0.
- INIT behaviour, each cycle:
  - ram_wren_o = 1, ram_wrad_o = counter, ram_wrda_o = 0; counter increments.
  - When counter = OPTION_RF_WORDS-1, the write still happens and the next state is RUN.
- In INIT, rf_re_i and wb_we_i are ignored:
  - ram_rden_o = 0;
  - writeback data is dropped, not queued.
- RUN writes:
  - ram_wren_o = wb_we_i & !(OPTION_RF_R0_ZERO & wb_adr_i == 0).
  - ram_wrad_o = wb_adr_i, ram_wrda_o = wb_dat_i.
- RUN reads:
  - ram_rden_o = rf_re_i.
  - RAM read addresses are rfa_adr_i / rfb_adr_i.
  - Each port registers its last read address (last_adr_x) when rf_re_i = 1.
- Per-port bypass register (byp_vld_x, byp_dat_x). Read data = byp_vld_x ? byp_dat_x : ram_rdda_x_i.
- Rules per port, evaluated each RUN cycle, with "effective write" = ram_wren_o:
  - rf_re_i = 1 and effective write to the same address: byp_vld <= 1, byp_dat <= wb_dat_i. The RAM value is undefined for this case.
  - rf_re_i = 1, no address match: byp_vld <= 0.
  - rf_re_i = 0 and effective write to last_adr_x: byp_vld <= 1, byp_dat <= wb_dat_i. The held output tracks the new register value.
  - rf_re_i = 0, no match: bypass unchanged.
- OPTION_RF_R0_ZERO = 1 and a read of address 0: byp_vld <= 1, byp_dat <= 0, regardless of writes.
- Reset values:
  - busy_o = 1, ram_wren_o = 0, ram_rden_o = 0;
  - byp_vld_a/b = 1 and byp_dat_a/b = 0, so rfa_o = rfb_o = 0;
  - last_adr_a/b = 0, counter = 0.
- ram_wren_o, ram_wrad_o, ram_wrda_o and ram_rden_o are combinational from the state register and inputs. In reset they equal 0.

## Timing
- Init lasts exactly OPTION_RF_WORDS cycles after rst_n rises. busy_o falls in the cycle after the write to address OPTION_RF_WORDS-1.
- Read latency is 1 cycle: address with rf_re_i = 1 in cycle N gives data on rfa_o/rfb_o in cycle N+1.
- Write to register X in cycle N is visible to a read issued in cycle N, because the bypass covers it.
- With rf_re_i = 0, outputs hold their value, except where an effective write matches last_adr_x; then the new value appears one cycle later.
- rst_n asserted mid-INIT or mid-RUN:
  - all state resets immediately;
  - on release, init restarts from address 0.
- Both ports may read the same address; each bypass operates independently.

## Test plan
- Reset release, WORDS = 32 → ram_wren_o = 1 for 32 cycles with addresses 0..31 and data 0; busy_o falls on cycle 32; rfa_o = rfb_o = 0.
- During INIT, drive wb_we_i = 1, adr 5, dat 0xDEAD; after init, read r5 → rfa_o = 0.
- RUN: write r3 = 0x12345678 and read A = r3, B = r4 in the same cycle → next cycle rfa_o = 0x12345678, rfb_o = 0.
- Read r7 (value 0x11), then hold rf_re_i = 0 and write r7 = 0x22 → rfa_o changes from 0x11 to 0x22 one cycle later. A write to r8 leaves rfa_o unchanged.
- R0_ZERO = 1: write r0 = 0xFFFF_FFFF → ram_wren_o stays 0; reading r0 on both ports → 0.
- Assert rst_n low in RUN mid-read → outputs go to 0 immediately, busy_o = 1; on release, init restarts at address 0.

Source files
------------

// File: rtl/mor1kx_rf_ctrl.sv
// ----------------------------------------------------------------------------
// mor1kx_rf_ctrl
//
// Front end for a register file built from synchronous-read RAMs, one RAM
// per read port (A, B) sharing a single write port. The RAMs have no reset
// and no defined read-during-write behaviour, so this block:
//   * clears every RAM word after reset (INIT state, one word per cycle),
//   * hides same-cycle write/read hazards and keeps a held (non-reading)
//     output in step with writes to the register it last read, using one
//     bypass register per port,
//   * optionally makes r0 read as zero and drops writes to it.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   busy_o            high while the init sequence runs; no reads/writes then
//   rfa_adr_i/rfb_adr_i  read addresses for ports A and B
//   rf_re_i           read enable shared by both ports
//   rfa_o/rfb_o       read data, one cycle after the address
//   wb_adr_i/wb_we_i/wb_dat_i  writeback address, enable and data
//   ram_rdad_a_o/ram_rdad_b_o  read addresses to RAM A / RAM B
//   ram_rden_o        read enable to both RAMs
//   ram_rdda_a_i/ram_rdda_b_i  registered read data from RAM A / RAM B
//   ram_wrad_o/ram_wren_o/ram_wrda_o  write port shared by both RAMs
// ----------------------------------------------------------------------------
module mor1kx_rf_ctrl #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int OPTION_RF_WORDS      = 32,
    parameter int OPTION_RF_R0_ZERO    = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,

    output logic                            busy_o,

    input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfa_adr_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfb_adr_i,
    input  logic                            rf_re_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] rfa_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] rfb_o,

    input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_adr_i,
    input  logic                            wb_we_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wb_dat_i,

    output logic [OPTION_RF_ADDR_WIDTH-1:0] ram_rdad_a_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0] ram_rdad_b_o,
    output logic                            ram_rden_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ram_rdda_a_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ram_rdda_b_i,

    output logic [OPTION_RF_ADDR_WIDTH-1:0] ram_wrad_o,
    output logic                            ram_wren_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] ram_wrda_o
);

    localparam int AW = OPTION_RF_ADDR_WIDTH;
    localparam int DW = OPTION_OPERAND_WIDTH;

    localparam bit                R0_ZERO   = (OPTION_RF_R0_ZERO != 0);
    localparam logic [AW-1:0]     LAST_WORD = AW'(OPTION_RF_WORDS - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Everything one read port remembers between cycles.
    typedef struct packed {
        logic          vld;   // output comes from dat instead of the RAM
        logic [DW-1:0] dat;   // bypass value
        logic [AW-1:0] last;  // address of the most recent read
    } port_t;

    localparam port_t PORT_RESET = '{vld: 1'b1, dat: '0, last: '0};

    state_t        state_q, state_d;
    logic [AW-1:0] counter_q, counter_d;
    port_t         port_a_q, port_a_d;
    port_t         port_b_q, port_b_d;

    // ------------------------------------------------------------------
    // Next bypass state for one port in RUN.
    //   * A read of r0 (when r0 is hard-wired) always returns zero.
    //   * A read that collides with an effective write takes the write
    //     data, because the RAM output is undefined in that case.
    //   * Any other read returns the RAM output.
    //   * With no read, the held output follows writes to the register it
    //     last read, so it always shows that register's current value.
    // ------------------------------------------------------------------
    function automatic port_t port_next(
        input port_t         cur,
        input logic          re,
        input logic [AW-1:0] rd_adr,
        input logic          wren,
        input logic [AW-1:0] wr_adr,
        input logic [DW-1:0] wr_dat
    );
        port_t nxt;
        nxt = cur;
        if (re) begin
            nxt.last = rd_adr;
            if (R0_ZERO && (rd_adr == '0)) begin
                nxt.vld = 1'b1;
                nxt.dat = '0;
            end else if (wren && (wr_adr == rd_adr)) begin
                nxt.vld = 1'b1;
                nxt.dat = wr_dat;
            end else begin
                nxt.vld = 1'b0;
            end
        end else if (wren && (wr_adr == cur.last)) begin
            nxt.vld = 1'b1;
            nxt.dat = wr_dat;
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // RAM control. Combinational from the state register and the inputs;
    // forced to zero while rst_n is low so the RAMs are never written
    // during reset even though the state register already reads INIT.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        ram_wren_o = 1'b0;
        ram_wrad_o = '0;
        ram_wrda_o = '0;
        ram_rden_o = 1'b0;

        if (rst_n) begin
            if (state_q == ST_INIT) begin
                // Clear one word per cycle; upstream reads and writes are
                // ignored, and writeback data is dropped.
                ram_wren_o = 1'b1;
                ram_wrad_o = counter_q;
            end else begin
                ram_wren_o = wb_we_i & ~(R0_ZERO & (wb_adr_i == '0));
                ram_wrad_o = wb_adr_i;
                ram_wrda_o = wb_dat_i;
                ram_rden_o = rf_re_i;
            end
        end
    end

    assign ram_rdad_a_o = rfa_adr_i;
    assign ram_rdad_b_o = rfb_adr_i;

    assign busy_o = (state_q == ST_INIT);

    assign rfa_o = port_a_q.vld ? port_a_q.dat : ram_rdda_a_i;
    assign rfb_o = port_b_q.vld ? port_b_q.dat : ram_rdda_b_i;

    // ------------------------------------------------------------------
    // Next-state logic: init sequencer and per-port bypass.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        port_a_d  = port_a_q;
        port_b_d  = port_b_q;

        if (state_q == ST_INIT) begin
            // The write to LAST_WORD still happens this cycle; RUN follows.
            counter_d = counter_q + AW'(1);
            if (counter_q == LAST_WORD) begin
                state_d = ST_RUN;
            end
        end else begin
            port_a_d = port_next(port_a_q, rf_re_i, rfa_adr_i,
                                 ram_wren_o, wb_adr_i, wb_dat_i);
            port_b_d = port_next(port_b_q, rf_re_i, rfb_adr_i,
                                 ram_wren_o, wb_adr_i, wb_dat_i);
        end
    end

    // ------------------------------------------------------------------
    // State registers. The RAMs themselves cannot be reset; the bypass
    // registers reset valid with zero data so both outputs read zero
    // until the first real read, and the init sequence makes the RAM
    // contents agree with that.
    // NOTE: the RAM arrays are deliberately not reset here; clearing them
    // is done by the INIT write sweep instead of a reset on every word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            counter_q <= '0;
            port_a_q  <= PORT_RESET;
            port_b_q  <= PORT_RESET;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q   <= state_d;
            counter_q <= counter_d;
            port_a_q  <= port_a_d;
            port_b_q  <= port_b_d;
        end
    end

endmodule
